// File: rtl/gpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpu_sram_arbiter
// Description : Round-robin arbiter sharing the GPU SRAM port between the
//               clear/fill engine (port 0) and the raster engine (port 1).
//               Grants only during blanking, issues pipelined writes and
//               two-cycle reads, and drops addresses outside the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_sram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int MAX_ADDR = 255999
) (
  input  logic              I_CLK,
  input  logic              I_RST_N,
  input  logic              I_VIDEO_ON,
  // requester 0: clear/fill engine
  input  logic              I_R0_VALID,
  input  logic              I_R0_WE,
  input  logic [ADDR_W-1:0] I_R0_ADDR,
  input  logic [DATA_W-1:0] I_R0_DATA,
  output logic              O_R0_READY,
  // requester 1: line/triangle raster engine
  input  logic              I_R1_VALID,
  input  logic              I_R1_WE,
  input  logic [ADDR_W-1:0] I_R1_ADDR,
  input  logic [DATA_W-1:0] I_R1_DATA,
  output logic              O_R1_READY,
  // read return
  output logic              O_RD_VALID,
  output logic              O_RD_ID,
  output logic [DATA_W-1:0] O_RD_DATA,
  // SRAM side
  input  logic [DATA_W-1:0] I_GPU_DATA,
  output logic [ADDR_W-1:0] O_GPU_ADDR,
  output logic [DATA_W-1:0] O_GPU_DATA,
  output logic              O_GPU_WRITE,
  output logic              O_GPU_READ,
  // status
  output logic [7:0]        O_DROP_CNT,
  output logic              O_BUSY
);

  localparam logic [ADDR_W-1:0] C_MAX_ADDR = ADDR_W'(MAX_ADDR);
  localparam logic [7:0]        C_DROP_SAT = 8'hFF;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_RD_ISSUE   = 2'd1,
    ST_RD_CAPTURE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // last port that transferred; the other port wins the next tie
  logic                r_last;

  logic                w_can_accept;
  logic                w_r0_ready;
  logic                w_r1_ready;
  logic                w_xfer0;
  logic                w_xfer1;
  logic                w_xfer;
  logic                w_sel_port;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_in_range;

  // outstanding read bookkeeping
  logic                r_rd_port;
  logic                r_rd_drop;

  // output registers
  logic [ADDR_W-1:0]   r_gpu_addr;
  logic [DATA_W-1:0]   r_gpu_data;
  logic                r_gpu_write;
  logic                r_gpu_read;
  logic                r_rd_valid;
  logic                r_rd_id;
  logic [DATA_W-1:0]   r_rd_data;
  logic [7:0]          r_drop_cnt;

  // State register
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Readiness, grant selection and next-state decode
  always_comb begin
    w_state_next = r_state;
    w_can_accept = I_RST_N & (r_state == ST_RUN) & ~I_VIDEO_ON;
    // readies are mutually exclusive when both ports are valid
    w_r0_ready   = w_can_accept & (~I_R1_VALID | r_last);
    w_r1_ready   = w_can_accept & (~I_R0_VALID | ~r_last);
    w_xfer0      = I_R0_VALID & w_r0_ready;
    w_xfer1      = I_R1_VALID & w_r1_ready;
    w_xfer       = w_xfer0 | w_xfer1;
    w_sel_port   = w_xfer1;
    w_sel_we     = w_xfer1 ? I_R1_WE   : I_R0_WE;
    w_sel_addr   = w_xfer1 ? I_R1_ADDR : I_R0_ADDR;
    w_sel_data   = w_xfer1 ? I_R1_DATA : I_R0_DATA;
    w_in_range   = (w_sel_addr <= C_MAX_ADDR);

    case (r_state)
      ST_RUN: begin
        // every accepted read, in range or dropped, walks the read pipeline
        if (w_xfer && !w_sel_we) begin
          w_state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE:   w_state_next = ST_RD_CAPTURE;
      ST_RD_CAPTURE: w_state_next = ST_RUN;
      default:       w_state_next = ST_RUN;
    endcase
  end

  // Round-robin history: remember who was served last
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_last <= 1'b1;
    end else if (w_xfer) begin
      r_last <= w_sel_port;
    end
  end

  // SRAM command registers: strobes pulse for one cycle after a transfer
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_gpu_addr  <= '0;
      r_gpu_data  <= '0;
      r_gpu_write <= 1'b0;
      r_gpu_read  <= 1'b0;
    end else begin
      r_gpu_write <= w_xfer & w_sel_we & w_in_range;
      r_gpu_read  <= w_xfer & ~w_sel_we & w_in_range;
      // address/data only move for a real access; they hold when idle
      if (w_xfer && w_in_range) begin
        r_gpu_addr <= w_sel_addr;
        if (w_sel_we) begin
          r_gpu_data <= w_sel_data;
        end
      end
    end
  end

  // Capture which port owns the outstanding read and whether it was dropped
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_rd_port <= 1'b0;
      r_rd_drop <= 1'b0;
    end else if (w_xfer && !w_sel_we) begin
      r_rd_port <= w_sel_port;
      r_rd_drop <= ~w_in_range;
    end
  end

  // Read return: data sampled from SRAM at the end of RD_CAPTURE
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_rd_valid <= 1'b0;
      r_rd_id    <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= (r_state == ST_RD_CAPTURE);
      if (r_state == ST_RD_CAPTURE) begin
        r_rd_id   <= r_rd_port;
        r_rd_data <= r_rd_drop ? '0 : I_GPU_DATA;
      end
    end
  end

  // Saturating count of out-of-range requests
  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_drop_cnt <= 8'h00;
    end else if (w_xfer && !w_in_range && (r_drop_cnt != C_DROP_SAT)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end

  assign O_R0_READY  = w_r0_ready;
  assign O_R1_READY  = w_r1_ready;
  assign O_GPU_ADDR  = r_gpu_addr;
  assign O_GPU_DATA  = r_gpu_data;
  assign O_GPU_WRITE = r_gpu_write;
  assign O_GPU_READ  = r_gpu_read;
  assign O_RD_VALID  = r_rd_valid;
  assign O_RD_ID     = r_rd_id;
  assign O_RD_DATA   = r_rd_data;
  assign O_DROP_CNT  = r_drop_cnt;
  assign O_BUSY      = (r_state != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_gpu_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_sram_arbiter
// Description : Directed self-checking bench for gpu_sram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_sram_arbiter;

  logic        I_CLK;
  logic        I_RST_N;
  logic        I_VIDEO_ON;
  logic        I_R0_VALID;
  logic        I_R0_WE;
  logic [17:0] I_R0_ADDR;
  logic [15:0] I_R0_DATA;
  logic        O_R0_READY;
  logic        I_R1_VALID;
  logic        I_R1_WE;
  logic [17:0] I_R1_ADDR;
  logic [15:0] I_R1_DATA;
  logic        O_R1_READY;
  logic        O_RD_VALID;
  logic        O_RD_ID;
  logic [15:0] O_RD_DATA;
  logic [15:0] I_GPU_DATA;
  logic [17:0] O_GPU_ADDR;
  logic [15:0] O_GPU_DATA;
  logic        O_GPU_WRITE;
  logic        O_GPU_READ;
  logic [7:0]  O_DROP_CNT;
  logic        O_BUSY;

  int n_cmp;
  int n_fail;

  gpu_sram_arbiter u_dut (
    .I_CLK      (I_CLK),
    .I_RST_N    (I_RST_N),
    .I_VIDEO_ON (I_VIDEO_ON),
    .I_R0_VALID (I_R0_VALID),
    .I_R0_WE    (I_R0_WE),
    .I_R0_ADDR  (I_R0_ADDR),
    .I_R0_DATA  (I_R0_DATA),
    .O_R0_READY (O_R0_READY),
    .I_R1_VALID (I_R1_VALID),
    .I_R1_WE    (I_R1_WE),
    .I_R1_ADDR  (I_R1_ADDR),
    .I_R1_DATA  (I_R1_DATA),
    .O_R1_READY (O_R1_READY),
    .O_RD_VALID (O_RD_VALID),
    .O_RD_ID    (O_RD_ID),
    .O_RD_DATA  (O_RD_DATA),
    .I_GPU_DATA (I_GPU_DATA),
    .O_GPU_ADDR (O_GPU_ADDR),
    .O_GPU_DATA (O_GPU_DATA),
    .O_GPU_WRITE(O_GPU_WRITE),
    .O_GPU_READ (O_GPU_READ),
    .O_DROP_CNT (O_DROP_CNT),
    .O_BUSY     (O_BUSY)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // advance past the next rising edge; registered outputs are then stable
  task automatic tick();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    I_R0_VALID = 1'b0; I_R0_WE = 1'b0; I_R0_ADDR = '0; I_R0_DATA = '0;
    I_R1_VALID = 1'b0; I_R1_WE = 1'b0; I_R1_ADDR = '0; I_R1_DATA = '0;
  endtask

  initial begin
    int i0;
    int i1;
    logic lastm;
    logic expp;
    n_cmp = 0;
    n_fail = 0;
    I_RST_N = 1'b0;
    I_VIDEO_ON = 1'b0;
    I_GPU_DATA = 16'h0000;
    idle_inputs();

    // ---------------- reset state ----------------
    I_R0_VALID = 1'b1; I_R1_VALID = 1'b1;
    tick(); tick();
    chk("rst_r0_ready", 32'(O_R0_READY), 32'd0);
    chk("rst_r1_ready", 32'(O_R1_READY), 32'd0);
    chk("rst_write",    32'(O_GPU_WRITE), 32'd0);
    chk("rst_read",     32'(O_GPU_READ), 32'd0);
    chk("rst_addr",     32'(O_GPU_ADDR), 32'd0);
    chk("rst_data",     32'(O_GPU_DATA), 32'd0);
    chk("rst_rdvalid",  32'(O_RD_VALID), 32'd0);
    chk("rst_rdid",     32'(O_RD_ID), 32'd0);
    chk("rst_rddata",   32'(O_RD_DATA), 32'd0);
    chk("rst_drop",     32'(O_DROP_CNT), 32'd0);
    chk("rst_busy",     32'(O_BUSY), 32'd0);
    idle_inputs();
    I_RST_N = 1'b1;
    tick();

    // ---------------- port 0 streaming writes 0..3 ----------------
    for (int i = 0; i < 4; i++) begin
      I_R0_VALID = 1'b1; I_R0_WE = 1'b1; I_R0_ADDR = 18'(i); I_R0_DATA = 16'hFFFF;
      #1;
      chk("wr_r0_ready", 32'(O_R0_READY), 32'd1);
      tick();
      chk("wr_strobe", 32'(O_GPU_WRITE), 32'd1);
      chk("wr_addr",   32'(O_GPU_ADDR), 32'(i));
      chk("wr_data",   32'(O_GPU_DATA), 32'hFFFF);
    end
    idle_inputs();
    tick();
    chk("wr_idle_strobe", 32'(O_GPU_WRITE), 32'd0);
    chk("wr_idle_hold",   32'(O_GPU_ADDR), 32'd3);
    lastm = 1'b0;

    // ---------------- dual-port contention, 6 cycles ----------------
    i0 = 0; i1 = 0;
    for (int c = 0; c < 6; c++) begin
      I_R0_VALID = 1'b1; I_R0_WE = 1'b1; I_R0_ADDR = 18'(10 + i0); I_R0_DATA = 16'(16'h1000 + i0);
      I_R1_VALID = 1'b1; I_R1_WE = 1'b1; I_R1_ADDR = 18'(20 + i1); I_R1_DATA = 16'(16'h2000 + i1);
      expp = ~lastm;
      #1;
      chk("rr_r0_ready", 32'(O_R0_READY), 32'(expp == 1'b0));
      chk("rr_r1_ready", 32'(O_R1_READY), 32'(expp == 1'b1));
      tick();
      chk("rr_strobe", 32'(O_GPU_WRITE), 32'd1);
      if (expp) begin
        chk("rr_addr", 32'(O_GPU_ADDR), 32'(20 + i1));
        chk("rr_data", 32'(O_GPU_DATA), 32'(16'h2000 + i1));
        i1++;
      end else begin
        chk("rr_addr", 32'(O_GPU_ADDR), 32'(10 + i0));
        chk("rr_data", 32'(O_GPU_DATA), 32'(16'h1000 + i0));
        i0++;
      end
      lastm = expp;
    end
    chk("rr_count0", 32'(i0), 32'd3);
    idle_inputs();

    // ---------------- port 1 read of addr 100 ----------------
    I_R1_VALID = 1'b1; I_R1_WE = 1'b0; I_R1_ADDR = 18'd100;
    #1;
    chk("rd_r1_ready", 32'(O_R1_READY), 32'd1);
    tick();
    idle_inputs();
    I_R0_VALID = 1'b1; I_R0_WE = 1'b1; I_R0_ADDR = 18'd5; I_R0_DATA = 16'h0505;
    I_GPU_DATA = 16'h043F;
    #1;
    chk("rd_issue_read",  32'(O_GPU_READ), 32'd1);
    chk("rd_issue_addr",  32'(O_GPU_ADDR), 32'd100);
    chk("rd_issue_write", 32'(O_GPU_WRITE), 32'd0);
    chk("rd_issue_busy",  32'(O_BUSY), 32'd1);
    chk("rd_issue_r0rdy", 32'(O_R0_READY), 32'd0);
    tick();
    chk("rd_cap_read",    32'(O_GPU_READ), 32'd0);
    chk("rd_cap_rdvalid", 32'(O_RD_VALID), 32'd0);
    chk("rd_cap_r0rdy",   32'(O_R0_READY), 32'd0);
    tick();
    I_GPU_DATA = 16'h0000;
    chk("rd_ret_valid", 32'(O_RD_VALID), 32'd1);
    chk("rd_ret_id",    32'(O_RD_ID), 32'd1);
    chk("rd_ret_data",  32'(O_RD_DATA), 32'h043F);
    chk("rd_ret_busy",  32'(O_BUSY), 32'd0);
    chk("rd_ret_r0rdy", 32'(O_R0_READY), 32'd1);
    tick();
    idle_inputs();
    chk("rd_after_write", 32'(O_GPU_WRITE), 32'd1);
    chk("rd_after_addr",  32'(O_GPU_ADDR), 32'd5);
    chk("rd_pulse_end",   32'(O_RD_VALID), 32'd0);
    chk("rd_data_hold",   32'(O_RD_DATA), 32'h043F);
    chk("rd_id_hold",     32'(O_RD_ID), 32'd1);

    // ---------------- out-of-range drops and boundary ----------------
    I_R0_VALID = 1'b1; I_R0_WE = 1'b1; I_R0_ADDR = 18'd256000; I_R0_DATA = 16'h1234;
    tick();
    chk("drop_wr_strobe", 32'(O_GPU_WRITE), 32'd0);
    chk("drop_wr_cnt",    32'(O_DROP_CNT), 32'd1);
    chk("drop_wr_hold",   32'(O_GPU_ADDR), 32'd5);
    I_R0_ADDR = 18'd255999; I_R0_DATA = 16'hABCD;
    tick();
    chk("edge_wr_strobe", 32'(O_GPU_WRITE), 32'd1);
    chk("edge_wr_addr",   32'(O_GPU_ADDR), 32'd255999);
    chk("edge_wr_cnt",    32'(O_DROP_CNT), 32'd1);
    I_R0_WE = 1'b0; I_R0_ADDR = 18'h3FFFF; I_GPU_DATA = 16'h5555;
    tick();
    idle_inputs();
    chk("drop_rd_read", 32'(O_GPU_READ), 32'd0);
    chk("drop_rd_busy", 32'(O_BUSY), 32'd1);
    chk("drop_rd_cnt",  32'(O_DROP_CNT), 32'd2);
    tick();
    chk("drop_rd_cap_read", 32'(O_GPU_READ), 32'd0);
    tick();
    I_GPU_DATA = 16'h0000;
    chk("drop_rd_valid", 32'(O_RD_VALID), 32'd1);
    chk("drop_rd_data",  32'(O_RD_DATA), 32'h0000);
    chk("drop_rd_id",    32'(O_RD_ID), 32'd0);

    // ---------------- VIDEO_ON skid ----------------
    I_R1_VALID = 1'b1; I_R1_WE = 1'b1; I_R1_ADDR = 18'd7; I_R1_DATA = 16'h7777;
    tick();
    I_VIDEO_ON = 1'b1;
    I_R1_ADDR = 18'd8; I_R1_DATA = 16'h8888;
    #1;
    chk("vid_skid_write", 32'(O_GPU_WRITE), 32'd1);
    chk("vid_skid_addr",  32'(O_GPU_ADDR), 32'd7);
    chk("vid_r1_ready",   32'(O_R1_READY), 32'd0);
    tick();
    chk("vid_no_write",   32'(O_GPU_WRITE), 32'd0);
    chk("vid_r1_ready2",  32'(O_R1_READY), 32'd0);
    tick();
    chk("vid_r1_ready3",  32'(O_R1_READY), 32'd0);
    I_VIDEO_ON = 1'b0;
    #1;
    chk("vid_off_ready",  32'(O_R1_READY), 32'd1);
    tick();
    idle_inputs();
    chk("vid_off_write",  32'(O_GPU_WRITE), 32'd1);
    chk("vid_off_addr",   32'(O_GPU_ADDR), 32'd8);

    // ---------------- reset during RD_ISSUE ----------------
    I_R0_VALID = 1'b1; I_R0_WE = 1'b0; I_R0_ADDR = 18'd50;
    tick();
    idle_inputs();
    chk("rrst_issue_busy", 32'(O_BUSY), 32'd1);
    chk("rrst_issue_read", 32'(O_GPU_READ), 32'd1);
    I_RST_N = 1'b0;
    tick();
    chk("rrst_read",  32'(O_GPU_READ), 32'd0);
    chk("rrst_busy",  32'(O_BUSY), 32'd0);
    chk("rrst_drop",  32'(O_DROP_CNT), 32'd0);
    I_RST_N = 1'b1;
    tick();
    chk("rrst_no_ret1", 32'(O_RD_VALID), 32'd0);
    tick();
    chk("rrst_no_ret2", 32'(O_RD_VALID), 32'd0);
    chk("rrst_rddata",  32'(O_RD_DATA), 32'd0);
    // after reset port 0 wins the first tie
    I_R0_VALID = 1'b1; I_R0_WE = 1'b1; I_R0_ADDR = 18'd1;
    I_R1_VALID = 1'b1; I_R1_WE = 1'b1; I_R1_ADDR = 18'd2;
    #1;
    chk("tie_r0_ready", 32'(O_R0_READY), 32'd1);
    chk("tie_r1_ready", 32'(O_R1_READY), 32'd0);
    idle_inputs();
    #1;

    // ---------------- drop counter saturation ----------------
    I_R0_VALID = 1'b1; I_R0_WE = 1'b1; I_R0_ADDR = 18'h3FFFF;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 100) chk("sat_cnt_100", 32'(O_DROP_CNT), 32'd100);
      if (k == 255) chk("sat_cnt_255", 32'(O_DROP_CNT), 32'd255);
    end
    chk("sat_cnt_300", 32'(O_DROP_CNT), 32'd255);
    chk("sat_no_write", 32'(O_GPU_WRITE), 32'd0);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
